// File: rtl/top_mapache_video_bus_pkg.sv
// Mapache video bus: address map, VGA timing and render pipeline types.
// Shared by the timing generator and the bus/render top.
package top_mapache_video_bus_pkg;

    localparam logic [15:0] RAM_LAST  = 16'h36FF;
    localparam logic [15:0] PMF_BASE  = 16'h3700;
    localparam logic [15:0] PMF_LAST  = 16'h38FF;
    localparam logic [15:0] PMB_BASE  = 16'h3900;
    localparam logic [15:0] PMB_LAST  = 16'h3AFF;
    localparam logic [15:0] NTBL_BASE = 16'h3B00;
    localparam logic [15:0] NTBL_LAST = 16'h3EBF;
    localparam logic [15:0] PAL_ADDR  = 16'h3EC0;
    localparam logic [15:0] RSVD_LAST = 16'h3EFF;
    localparam logic [15:0] OBM_BASE  = 16'h3F00;
    localparam logic [15:0] OBM_LAST  = 16'h3FFF;
    localparam logic [15:0] CTRL_BASE = 16'h7000;
    localparam logic [15:0] CTRL_LAST = 16'h7001;

    localparam int PMF_SIZE  = 512;
    localparam int PMB_SIZE  = 512;
    localparam int NTBL_SIZE = 960;
    localparam int OBM_SIZE  = 256;

    localparam logic [8:0] H_VISIBLE = 9'd320;
    localparam logic [8:0] H_FRONT   = 9'd8;
    localparam logic [8:0] H_SYNC    = 9'd48;
    localparam logic [8:0] H_BACK    = 9'd24;
    localparam logic [8:0] H_TOTAL   = 9'd400;
    localparam logic [8:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [8:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = 10'd525;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [8:0] GAME_X0 = 9'd32;
    localparam logic [8:0] GAME_X1 = 9'd288;

    typedef enum logic [2:0] {
        RG_NONE, RG_PMF, RG_PMB, RG_NTBL,
        RG_PAL, RG_RSVD, RG_OBM
    } region_e;

    typedef struct packed {
        logic       act;
        logic       hs_n;
        logic       vs_n;
        logic [2:0] px;
        logic [2:0] row;
    } fetch_stage_t;

    typedef struct packed {
        logic       act;
        logic       hs_n;
        logic       vs_n;
        logic       swap;
        logic [1:0] sel;
    } pixel_stage_t;

    function automatic region_e vram_region(
        input logic [15:0] a
    );
        region_e r;
        if (a < PMF_BASE || a > OBM_LAST) r = RG_NONE;
        else if (a <= PMF_LAST)          r = RG_PMF;
        else if (a <= PMB_LAST)          r = RG_PMB;
        else if (a <= NTBL_LAST)         r = RG_NTBL;
        else if (a == PAL_ADDR)          r = RG_PAL;
        else if (a <= RSVD_LAST)         r = RG_RSVD;
        else                             r = RG_OBM;
        return r;
    endfunction

    // Regions are at most 1 KiB, so a 10-bit modular offset is exact.
    function automatic logic [9:0] region_off(
        input logic [15:0] a,
        input region_e     r
    );
        logic [15:0] base;
        case (r)
            RG_PMB:  base = PMB_BASE;
            RG_NTBL: base = NTBL_BASE;
            RG_OBM:  base = OBM_BASE;
            default: base = PMF_BASE;
        endcase
        return 10'(a - base);
    endfunction

    function automatic logic [2:0] pixel_colour(
        input logic [1:0] code,
        input logic       swap,
        input logic [5:0] pal
    );
        logic [2:0] c;
        case (code)
            2'd0:    c = 3'b000;
            2'd1:    c = swap ? pal[5:3] : pal[2:0];
            2'd2:    c = swap ? pal[2:0] : pal[5:3];
            default: c = 3'b111;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/top_mapache_video_bus_vga_timing.sv
// VGA raster counters with sync, vblank and game-area coordinates.
// Outputs are combinational from the counters; the top pipelines them.
module vga_timing_m
    import top_mapache_video_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] gx,
    output logic [7:0] gy,
    output logic       game_act,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       vblank
);

    logic [8:0] h;
    logic [9:0] v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_TOTAL - 9'd1) begin
            h <= '0;
            v <= (v == V_TOTAL - 10'd1) ? '0 : v + 10'd1;
        end else begin
            h <= h + 9'd1;
        end
    end

    always_comb begin
        hsync_n  = !(h >= H_SYNC_START && h < H_SYNC_END);
        vsync_n  = !(v >= V_SYNC_START && v < V_SYNC_END);
        vblank   = v >= V_VISIBLE;
        game_act = h >= GAME_X0 && h < GAME_X1 &&
                   v < V_VISIBLE;
        gx       = 8'(h - GAME_X0);
        gy       = v[8:1];
    end

endmodule

// File: rtl/top_mapache_video_bus.sv
// CPU bus decode, VRAM with CPU and render ports, and the
// three-stage tile renderer driving the VGA outputs.
module top_mapache_video_bus
    import top_mapache_video_bus_pkg::*;
(
    input  logic        clk_12_5875,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        fpga_data_enable,
    input  logic        write_enable_B,
    output logic [14:0] output_address,
    output logic        SELECT_ram_B,
    output logic        SELECT_rom_B,
    output logic        SELECT_controller,
    output logic        vblank_irq_B,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        hsync,
    output logic        vsync
);

    region_e    vram_sel;
    logic [9:0] off;
    logic [7:0] rd_mux;
    logic [7:0] pmf  [PMF_SIZE];
    logic [7:0] pmb  [PMB_SIZE];
    logic [7:0] ntbl [NTBL_SIZE];
    logic [7:0] obm  [OBM_SIZE];
    logic [7:0] palette;

    always_comb begin
        vram_sel = vram_region(cpu_address);
        off      = region_off(cpu_address, vram_sel);
    end

    assign output_address    = cpu_address[14:0];
    assign SELECT_ram_B      = !(cpu_address <= RAM_LAST);
    assign SELECT_rom_B      = !cpu_address[15];
    assign SELECT_controller = cpu_address >= CTRL_BASE &&
                               cpu_address <= CTRL_LAST;
    assign fpga_data_enable  = write_enable_B &&
                               vram_sel != RG_NONE;

    // VRAM is never cleared and stays writable through reset.
    always_ff @(posedge clk_12_5875) begin
        if (!write_enable_B) begin
            case (vram_sel)
                RG_PMF:  pmf[off[8:0]]  <= data_in;
                RG_PMB:  pmb[off[8:0]]  <= data_in;
                RG_NTBL: ntbl[off]      <= data_in;
                RG_PAL:  palette        <= data_in;
                RG_OBM:  obm[off[7:0]]  <= data_in;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (vram_sel)
            RG_PMF:  rd_mux = pmf[off[8:0]];
            RG_PMB:  rd_mux = pmb[off[8:0]];
            RG_NTBL: rd_mux = ntbl[off];
            RG_PAL:  rd_mux = palette;
            RG_OBM:  rd_mux = obm[off[7:0]];
            default: rd_mux = '0;
        endcase
    end

    logic [7:0] gx;
    logic [7:0] gy;
    logic       game_act;
    logic       hs_n;
    logic       vs_n;
    logic       vblank;

    vga_timing_m u_timing (
        .clk      (clk_12_5875),
        .rst_n    (rst),
        .gx       (gx),
        .gy       (gy),
        .game_act (game_act),
        .hsync_n  (hs_n),
        .vsync_n  (vs_n),
        .vblank   (vblank)
    );

    assign vblank_irq_B = !vblank;

    fetch_stage_t s1;
    pixel_stage_t s2;
    logic [9:0]   ntbl_idx;
    logic [5:0]   tile_q;
    logic [7:0]   pat_q;
    logic [1:0]   code;
    logic [2:0]   colour;

    assign ntbl_idx = game_act ? {gy[7:3], gx[7:3]} : '0;

    // Render port: registered reads see the pre-write byte.
    always_ff @(posedge clk_12_5875) begin
        tile_q <= {ntbl[ntbl_idx][7], ntbl[ntbl_idx][4:0]};
        pat_q  <= pmb[{tile_q[4:0], s1.row, s1.px[2]}];
    end

    always_comb begin
        case (s2.sel)
            2'd0:    code = pat_q[7:6];
            2'd1:    code = pat_q[5:4];
            2'd2:    code = pat_q[3:2];
            default: code = pat_q[1:0];
        endcase
        colour = pixel_colour(code, s2.swap, palette[5:0]);
    end

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            s1       <= '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                          px: '0, row: '0};
            s2       <= '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                          swap: 1'b0, sel: '0};
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            data_out <= '0;
        end else begin
            s1       <= '{act: game_act, hs_n: hs_n, vs_n: vs_n,
                          px: gx[2:0], row: gy[2:0]};
            s2       <= '{act: s1.act, hs_n: s1.hs_n,
                          vs_n: s1.vs_n, swap: tile_q[5],
                          sel: s1.px[1:0]};
            r        <= s2.act ? {2{colour[2]}} : 2'b00;
            g        <= s2.act ? {2{colour[1]}} : 2'b00;
            b        <= s2.act ? {2{colour[0]}} : 2'b00;
            hsync    <= s2.hs_n;
            vsync    <= s2.vs_n;
            data_out <= rd_mux;
        end
    end

endmodule

// File: tb/tb_top_mapache_video_bus.sv
// Bench for top_mapache_video_bus: decode table, VRAM model with
// random traffic, and a spec-level raster/tile render model.
module tb_top_mapache_video_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        fpga_data_enable;
    logic        write_enable_B;
    logic [14:0] output_address;
    logic        SELECT_ram_B;
    logic        SELECT_rom_B;
    logic        SELECT_controller;
    logic        vblank_irq_B;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        hsync;
    logic        vsync;

    always #40 clk = ~clk;

    top_mapache_video_bus dut (
        .clk_12_5875       (clk),
        .rst               (rst),
        .cpu_address       (cpu_address),
        .data_in           (data_in),
        .data_out          (data_out),
        .fpga_data_enable  (fpga_data_enable),
        .write_enable_B    (write_enable_B),
        .output_address    (output_address),
        .SELECT_ram_B      (SELECT_ram_B),
        .SELECT_rom_B      (SELECT_rom_B),
        .SELECT_controller (SELECT_controller),
        .vblank_irq_B      (vblank_irq_B),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .hsync             (hsync),
        .vsync             (vsync)
    );

    int checks = 0;
    int failures = 0;

    // Byte model of 0x3700-0x3FFF
    logic [7:0] mm [0:2303];

    typedef struct {
        logic [15:0] a;
        logic        ram_b;
        logic        rom_b;
        logic        ctrl;
        logic        fde;
    } dec_t;

    dec_t dtab [14];
    logic [5:0] req032 [0:7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_vram(input logic [15:0] a);
        return a >= 16'h3700 && a <= 16'h3FFF;
    endfunction

    function automatic bit is_rsvd(input logic [15:0] a);
        return a >= 16'h3EC1 && a <= 16'h3EFF;
    endfunction

    function automatic logic [7:0] mread(input logic [15:0] a);
        if (!in_vram(a) || is_rsvd(a)) return 8'h00;
        return mm[int'(a) - 32'h3700];
    endfunction

    task automatic mwrite(input logic [15:0] a, input logic [7:0] d);
        if (in_vram(a) && !is_rsvd(a)) mm[int'(a) - 32'h3700] = d;
    endtask

    // Expected {r,g,b,hsync,vsync} for raster position (hh, vv)
    function automatic logic [7:0] exp_video(input int hh, input int vv);
        logic [2:0] col;
        logic [7:0] ent;
        logic [7:0] byt;
        logic [7:0] pal;
        logic [1:0] code;
        logic       hs;
        logic       vs;
        int gx, gy, pat, row, px;
        hs = !(hh >= 328 && hh < 376);
        vs = !(vv >= 490 && vv < 492);
        col = 3'b000;
        if (hh >= 32 && hh < 288 && vv < 480) begin
            gx   = hh - 32;
            gy   = vv / 2;
            ent  = mread(16'(32'h3B00 + (gy / 8) * 32 + gx / 8));
            pat  = int'(ent) % 32;
            row  = gy % 8;
            px   = gx % 8;
            byt  = mread(16'(32'h3900 + pat * 16 + row * 2 + px / 4));
            code = 2'(byt >> (6 - 2 * (px % 4)));
            pal  = mread(16'h3EC0);
            case (code)
                2'd0: col = 3'b000;
                2'd3: col = 3'b111;
                2'd1: col = ent[7] ? pal[5:3] : pal[2:0];
                default: col = ent[7] ? pal[2:0] : pal[5:3];
            endcase
        end
        return {{2{col[2]}}, {2{col[1]}}, {2{col[0]}}, hs, vs};
    endfunction

    // Called at a negedge; the data_out check lands one clk later.
    task automatic bus(input logic [15:0] a, input logic we_b,
                       input logic [7:0] d, input bit chk_rd);
        logic [7:0] e;
        cpu_address    = a;
        write_enable_B = we_b;
        data_in        = d;
        #1;
        chk("fde", fpga_data_enable, we_b && in_vram(a));
        e = mread(a);
        if (!we_b) mwrite(a, d);
        @(negedge clk);
        if (chk_rd) chk("read", data_out, e);
    endtask

    // Starts at the negedge on which counters were released at zero.
    task automatic render_run(input int cycles, input bit poke);
        logic [7:0] e;
        logic [7:0] hold;
        logic       prev_hs;
        int k, hx, prev_fall;
        prev_hs   = 1'b1;
        prev_fall = -1;
        hold      = '0;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk);
            k = n - 3;
            if (k < 0) e = 8'b0000_0011;
            else e = exp_video(k % 400, (k / 400) % 525);
            if (poke && k == 56) e = hold;
            chk("video", {r, g, b, hsync, vsync}, e);
            chk("vblank", vblank_irq_B, ((n / 400) % 525) < 480);
            hx = k % 400;
            if (k >= 0 && k < 800 && hx >= 40 && hx <= 47)
                chk("tile1_row0", {r, g, b}, req032[hx - 40]);
            if (prev_hs && !hsync) begin
                if (prev_fall >= 0) chk("hs_period", n - prev_fall, 400);
                prev_fall = n;
            end
            if (!prev_hs && hsync && prev_fall >= 0)
                chk("hs_width", n - prev_fall, 48);
            prev_hs = hsync;
            if (poke && n == 56) begin
                hold           = exp_video(56, 0);
                cpu_address    = 16'h3B03;
                data_in        = mread(16'h3B03) ^ 8'h9F;
                write_enable_B = 1'b0;
                mwrite(16'h3B03, data_in);
            end
            if (poke && n == 57) begin
                write_enable_B = 1'b1;
                cpu_address    = 16'h0000;
            end
        end
    endtask

    initial begin
        logic [15:0] a;
        dtab[0]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        dtab[1]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
        dtab[2]  = '{16'h36FF, 1'b0, 1'b1, 1'b0, 1'b0};
        dtab[3]  = '{16'h3700, 1'b1, 1'b1, 1'b0, 1'b1};
        dtab[4]  = '{16'h3EC1, 1'b1, 1'b1, 1'b0, 1'b1};
        dtab[5]  = '{16'h3FFF, 1'b1, 1'b1, 1'b0, 1'b1};
        dtab[6]  = '{16'h4000, 1'b1, 1'b1, 1'b0, 1'b0};
        dtab[7]  = '{16'h5000, 1'b1, 1'b1, 1'b0, 1'b0};
        dtab[8]  = '{16'h6FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        dtab[9]  = '{16'h7000, 1'b1, 1'b1, 1'b1, 1'b0};
        dtab[10] = '{16'h7001, 1'b1, 1'b1, 1'b1, 1'b0};
        dtab[11] = '{16'h7002, 1'b1, 1'b1, 1'b0, 1'b0};
        dtab[12] = '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
        dtab[13] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        req032 = '{6'b111111, 6'b000000, 6'b111111, 6'b000000,
                   6'b001100, 6'b001100, 6'b001100, 6'b001100};

        rst            = 1'b0;
        cpu_address    = 16'h0000;
        data_in        = 8'h00;
        write_enable_B = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {r, g, b, hsync, vsync, vblank_irq_B, data_out},
            {6'b0, 3'b111, 8'h00});
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cpu_address    = dtab[i].a;
            write_enable_B = 1'b1;
            #1;
            a = dtab[i].a;
            chk("decode",
                {SELECT_ram_B, SELECT_rom_B, SELECT_controller,
                 fpga_data_enable, output_address},
                {dtab[i].ram_b, dtab[i].rom_b, dtab[i].ctrl,
                 dtab[i].fde, a[14:0]});
            @(negedge clk);
        end
        cpu_address    = 16'h3800;
        write_enable_B = 1'b0;
        #1;
        chk("fde_on_write", fpga_data_enable, 1'b0);
        write_enable_B = 1'b1;
        @(negedge clk);

        for (int i = 16'h3700; i <= 16'h3FFF; i++)
            bus(16'(i), 1'b0, 8'($urandom), 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom % 8 == 0) a = 16'($urandom);
            else a = 16'h3700 + 16'($urandom_range(0, 2303));
            bus(a, ($urandom % 3) != 0, 8'($urandom), 1'b1);
        end
        bus(16'h3EC5, 1'b0, 8'hAB, 1'b1);
        bus(16'h3EC5, 1'b1, 8'h00, 1'b1);

        bus(16'h3700, 1'b0, 8'h99, 1'b1);
        bus(16'h3701, 1'b0, 8'h47, 1'b1);
        bus(16'h3700, 1'b1, 8'h00, 1'b1);
        chk("req030_a", data_out, 8'h99);
        bus(16'h3701, 1'b1, 8'h00, 1'b1);
        chk("req030_b", data_out, 8'h47);

        bus(16'h3900, 1'b0, 8'hCC, 1'b1);
        bus(16'h3901, 1'b0, 8'h55, 1'b1);
        bus(16'h3B01, 1'b0, 8'h80, 1'b1);
        bus(16'h3EC0, 1'b0, 8'h15, 1'b1);

        cpu_address    = 16'h0000;
        write_enable_B = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        render_run(4800, 1'b1);

        @(posedge clk);
        #10;
        rst = 1'b0;
        #1;
        chk("midframe_rst",
            {r, g, b, hsync, vsync, vblank_irq_B, data_out},
            {6'b0, 3'b111, 8'h00});
        @(negedge clk);
        bus(16'h3F10, 1'b0, 8'h5A, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        cpu_address    = 16'h0000;
        write_enable_B = 1'b1;
        rst = 1'b1;
        render_run(1200, 1'b0);

        bus(16'h3F10, 1'b1, 8'h00, 1'b1);
        bus(16'h3700, 1'b1, 8'h00, 1'b1);
        bus(16'h3EC0, 1'b1, 8'h00, 1'b1);
        bus(16'h3B03, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++)
            bus(16'h3700 + 16'($urandom_range(0, 2303)),
                1'b1, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_mapache_video_bus.md
TOP_MAPACHE_VIDEO_BUS -- requirements
Module: top_m

Interface
REQ-001 clk_12_5875  in  1  sole clock, 12.5875 MHz pixel clock; all state on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 cpu_address  in  16  CPU bus address.
REQ-004 data_in  in  8  CPU write data.
REQ-005 data_out  out  8  read data toward CPU.
REQ-006 fpga_data_enable  out  1  high when this block drives the CPU data bus.
REQ-007 write_enable_B  in  1  CPU write strobe, active-low; high = read.
REQ-008 output_address  out  15  cpu_address[14:0] passed to external RAM/ROM.
REQ-009 SELECT_ram_B / SELECT_rom_B  out  1 each  active-low external RAM/ROM chip selects.
REQ-010 SELECT_controller  out  1  active-high controller-port select.
REQ-011 vblank_irq_B  out  1  active-low vertical-blank interrupt.
REQ-012 r, g, b  out  2 each  VGA colour; hsync, vsync  out  1 each, active-low.

Function
REQ-013 Decode (combinational): 0x0000-0x36FF RAM_B=0; 0x3700-0x3FFF internal VRAM; 0x7000-0x7001 SELECT_controller=1; 0x8000-0xFFFF ROM_B=0; all other addresses select nothing; selects mutually exclusive.
REQ-014 VRAM map: PMF 0x3700-0x38FF (512 B), PMB 0x3900-0x3AFF (512 B), NTBL 0x3B00-0x3EBF (960 B, 32x30), PALETTE 0x3EC0 (1 B), reserved 0x3EC1-0x3EFF, OBM 0x3F00-0x3FFF (256 B).
REQ-015 Write: on each clk edge with write_enable_B=0 and address in VRAM, store data_in at that byte; reserved-region writes ignored; X/unknown bits stored as given.
REQ-016 Read: fpga_data_enable = write_enable_B & (address in VRAM); data_out registered, valid one clk after address; reserved bytes read 0x00.
REQ-017 Timing: h counter 0-399 (visible 0-319, front porch 8, sync 320+8..+55, back porch 24); v counter 0-524 (visible 0-479, sync lines 490-491); hsync/vsync low during sync.
REQ-018 Game area 256x240: horizontal game pixel = 1 clk at h 32-287, vertical = 2 lines (gy = v>>1); outside game area or blanking, rgb = 0.
REQ-019 Tile: entry NTBL[(gy>>3)*32 + (gx>>3)]; bits[4:0] pattern index, bit7 colour swap, bits[6:5] ignored.
REQ-020 PMB pattern = 16 B, 2 B per row: byte 2*row holds pixels 0-3, byte 2*row+1 pixels 4-7, MSB pair = leftmost pixel.
REQ-021 Colour: pixel 0 black, 3 white, 1 PALETTE[2:0], 2 PALETTE[5:3] (swapped if tile bit7); 3-bit value is {R,G,B}, each bit driven to 2'b11 or 2'b00.
REQ-022 rgb, hsync, vsync registered and delayed by the same fixed pipeline depth of 3 clks after counters.
REQ-023 vblank_irq_B low for v 480-524, high otherwise (level).
REQ-024 CPU write to same byte renderer reads in the same clk: renderer gets old value; render fetch never stalls CPU.
REQ-025 PMF and OBM stored and CPU-readable only; sprite rendering out of scope.

Reset
REQ-026 rst low: h=v=0, pipeline cleared, rgb=0, hsync=vsync=1, vblank_irq_B=1, data_out=0; VRAM contents not cleared.
REQ-027 Decode outputs stay combinational during reset; VRAM writes permitted during reset.

Structure
REQ-028 Shared package: region base/limit constants, timing constants (400/320/8/48/24, 525/480/10/2/33), game-area offsets.
REQ-029 One sub-module vga_timing_m (counters, sync, visible, vblank); VRAM arrays as dual-port memories inline.

Verification
REQ-030 Write 0x3700=0x99, 0x3701=0x47, then read -> data_out 0x99, 0x47 one clk later, fpga_data_enable=1.
REQ-031 Addresses 0x1234, 0x8000, 0x7001, 0x5000 -> RAM_B=0; ROM_B=0; controller=1; none selected; output_address = addr[14:0].
REQ-032 PMB 0x3900=0xCC, 0x3901=0x55, NTBL 0x3B01=0x80, PALETTE=0x15 -> tile(1,0) row 0: white,black,white,black, then PALETTE[5:3]=010 (g=11) x4.
REQ-033 Free-run -> hsync period 400 clks, low 48; vsync period 525 lines, low 2; vblank_irq_B low exactly lines 480-524.
REQ-034 Pull rst low mid-frame -> counters 0, rgb=0, syncs high immediately; VRAM data unchanged after release.
